bsr_tile_scheduler: RTL and testbench

Parametrised block-sparse-row scheduler driving the weight-stationary systolic array. It walks the row_ptr/col_idx metadata tables per K tile and loads each non-zero BLOCK_SIZE×BLOCK_SIZE weight block. For each block it streams all M activation tiles with per-beat tile coordinates toward the accumulator. New in this generation: programmable table and buffer bases, a variable-latency metadata handshake, downstream backpressure, configurable SRAM read latency, a dense fallback mode, metadata error detection and a processed-block counter.

---
 rtl/bsr_tile_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_bsr_tile_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsr_tile_scheduler.sv
// Block-sparse-row tile scheduler: walks row_ptr/col_idx metadata per K tile,
// loads each non-zero weight block row by row, then streams every M activation
// tile for that block toward the accumulator. Outputs are registered from the
// next-state values so they line up with the cycle a state is entered.
module bsr_tile_scheduler #(
  parameter int BLOCK_SIZE = 16,
  parameter int M_W        = 10,
  parameter int N_W        = 10,
  parameter int K_W        = 12,
  parameter int ADDR_W     = 32,
  parameter int META_AW    = 16,
  parameter int RD_LAT     = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  input  logic [M_W-1:0]     cfg_mt_i,
  input  logic [K_W-1:0]     cfg_kt_i,
  input  logic [N_W-1:0]     cfg_nt_i,
  input  logic               cfg_dense_i,
  input  logic [META_AW-1:0] cfg_row_ptr_base_i,
  input  logic [META_AW-1:0] cfg_col_idx_base_i,
  input  logic [ADDR_W-1:0]  cfg_wgt_base_i,
  input  logic [ADDR_W-1:0]  cfg_act_base_i,
  output logic               meta_req_o,
  output logic [META_AW-1:0] meta_addr_o,
  input  logic               meta_rvalid_i,
  input  logic [31:0]        meta_rdata_i,
  output logic               wgt_rd_en_o,
  output logic [ADDR_W-1:0]  wgt_addr_o,
  output logic               act_rd_en_o,
  output logic [ADDR_W-1:0]  act_addr_o,
  output logic               load_weight_o,
  output logic               pe_en_o,
  input  logic               pe_ready_i,
  output logic [M_W-1:0]     tile_m_o,
  output logic [N_W-1:0]     tile_n_o,
  output logic [K_W-1:0]     tile_k_o,
  output logic [31:0]        blk_count_o
);
  localparam int RW = $clog2(BLOCK_SIZE);

  typedef enum logic [3:0] {IDLE, PTR0, PTR1, CHECK, COL, LOAD, STREAM, NEXT, FIN} state_e;

  state_e             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d, kt_q, kt_d;
  logic [N_W-1:0]     n_q, n_d, nt_q, nt_d;
  logic [M_W-1:0]     m_q, m_d, mt_q, mt_d;
  logic [31:0]        blk_q, blk_d, ps_q, ps_d, pend_q, pend_d, cnt_q, cnt_d;
  logic [RW-1:0]      row_q, row_d;
  logic               dense_q, dense_d, err_q, err_d;
  logic [META_AW-1:0] rpb_q, rpb_d, cib_q, cib_d;
  logic [ADDR_W-1:0]  wb_q, wb_d, ab_q, ab_d;

  logic               meta_fire, beat;
  logic [K_W:0]       k_inc;
  logic [N_W:0]       n_inc;
  logic [32:0]        blk_inc;
  logic [63:0]        blk_eff, wgt_full, act_full;

  logic               busy_q, done_q, meta_req_q, wgt_rd_en_q, act_rd_en_q;
  logic [META_AW-1:0] meta_addr_q, meta_addr_d;
  logic [ADDR_W-1:0]  wgt_addr_q, act_addr_q;
  logic [M_W-1:0]     tm_q;
  logic [N_W-1:0]     tn_q;
  logic [K_W-1:0]     tk_q;
  logic [RD_LAT:1]    vld_pipe_q;

  assign meta_fire = meta_req_q & meta_rvalid_i;
  assign k_inc     = {1'b0, k_q} + {{K_W{1'b0}}, 1'b1};
  assign n_inc     = {1'b0, n_q} + {{N_W{1'b0}}, 1'b1};
  assign blk_inc   = {1'b0, blk_q} + 33'd1;

  // Next-state, loop counters and metadata bookkeeping
  always_comb begin
    state_d = state_q; k_d = k_q; n_d = n_q; m_d = m_q; blk_d = blk_q; row_d = row_q;
    ps_d = ps_q; pend_d = pend_q; err_d = err_q; cnt_d = cnt_q;
    mt_d = mt_q; kt_d = kt_q; nt_d = nt_q; dense_d = dense_q;
    rpb_d = rpb_q; cib_d = cib_q; wb_d = wb_q; ab_d = ab_q;
    beat = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        mt_d = cfg_mt_i; kt_d = cfg_kt_i; nt_d = cfg_nt_i; dense_d = cfg_dense_i;
        rpb_d = cfg_row_ptr_base_i; cib_d = cfg_col_idx_base_i;
        wb_d = cfg_wgt_base_i; ab_d = cfg_act_base_i;
        k_d = '0; n_d = '0; m_d = '0; row_d = '0; blk_d = '0; err_d = 1'b0; cnt_d = '0;
        if (cfg_mt_i == '0 || cfg_kt_i == '0 || (cfg_dense_i && cfg_nt_i == '0)) state_d = FIN;
        else if (cfg_dense_i) state_d = LOAD;
        else state_d = PTR0;
      end
      PTR0: if (meta_fire) begin ps_d = meta_rdata_i; state_d = PTR1; end
      PTR1: if (meta_fire) begin pend_d = meta_rdata_i; state_d = CHECK; end
      CHECK: begin
        blk_d = ps_q;
        if (pend_q < ps_q) begin err_d = 1'b1; state_d = FIN; end
        else if (pend_q == ps_q) state_d = NEXT;
        else state_d = COL;
      end
      COL: if (meta_fire) begin
        if (meta_rdata_i >= 32'(nt_q)) begin err_d = 1'b1; state_d = FIN; end
        else begin n_d = meta_rdata_i[N_W-1:0]; row_d = '0; state_d = LOAD; end
      end
      LOAD: begin
        if (row_q == RW'(BLOCK_SIZE - 1)) begin m_d = '0; state_d = STREAM; end
        else row_d = row_q + RW'(1);
      end
      STREAM: if (pe_ready_i) begin
        beat = 1'b1;
        if (m_q == mt_q - M_W'(1)) begin cnt_d = cnt_q + 32'd1; state_d = NEXT; end
        else m_d = m_q + M_W'(1);
      end
      NEXT: begin
        row_d = '0;
        if (dense_q) begin
          if (n_inc < {1'b0, nt_q}) begin n_d = n_inc[N_W-1:0]; state_d = LOAD; end
          else if (k_inc < {1'b0, kt_q}) begin k_d = k_inc[K_W-1:0]; n_d = '0; state_d = LOAD; end
          else state_d = FIN;
        end else begin
          if (blk_inc < {1'b0, pend_q}) begin blk_d = blk_inc[31:0]; state_d = COL; end
          else if (k_inc < {1'b0, kt_q}) begin k_d = k_inc[K_W-1:0]; state_d = PTR0; end
          else state_d = FIN;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a start in the same cycle.
    if (abort_i) begin
      state_d = IDLE; beat = 1'b0; err_d = err_q; cnt_d = cnt_q;
    end
  end

  // Address generation from the values the next cycle will hold
  always_comb begin
    blk_eff  = dense_d ? (64'(k_d) * 64'(nt_d) + 64'(n_d)) : 64'(blk_d);
    wgt_full = 64'(wb_d) + blk_eff * 64'(BLOCK_SIZE) + 64'(row_d);
    act_full = 64'(ab_q) + 64'(m_q) * 64'(kt_q) + 64'(k_q);
    meta_addr_d = meta_addr_q;
    case (state_d)
      PTR0:    meta_addr_d = rpb_d + META_AW'(k_d);
      PTR1:    meta_addr_d = rpb_d + META_AW'(k_d) + META_AW'(1);
      COL:     meta_addr_d = cib_d + META_AW'(blk_d);
      default: meta_addr_d = meta_addr_q;
    endcase
  end

  // Control state and latched configuration
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE; k_q <= '0; n_q <= '0; m_q <= '0; blk_q <= '0; row_q <= '0;
      ps_q <= '0; pend_q <= '0; err_q <= 1'b0; cnt_q <= '0;
      mt_q <= '0; kt_q <= '0; nt_q <= '0; dense_q <= 1'b0;
      rpb_q <= '0; cib_q <= '0; wb_q <= '0; ab_q <= '0;
    end else begin
      state_q <= state_d; k_q <= k_d; n_q <= n_d; m_q <= m_d; blk_q <= blk_d; row_q <= row_d;
      ps_q <= ps_d; pend_q <= pend_d; err_q <= err_d; cnt_q <= cnt_d;
      mt_q <= mt_d; kt_q <= kt_d; nt_q <= nt_d; dense_q <= dense_d;
      rpb_q <= rpb_d; cib_q <= cib_d; wb_q <= wb_d; ab_q <= ab_d;
    end
  end

  // Registered strobes/addresses; meta_req drops for one cycle after each response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0; done_q <= 1'b0; meta_req_q <= 1'b0; meta_addr_q <= '0;
      wgt_rd_en_q <= 1'b0; wgt_addr_q <= '0; act_rd_en_q <= 1'b0; act_addr_q <= '0;
      tm_q <= '0; tn_q <= '0; tk_q <= '0;
    end else begin
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_q == FIN) && !abort_i;
      meta_req_q  <= (state_d == PTR0 || state_d == PTR1 || state_d == COL) && !meta_fire;
      meta_addr_q <= meta_addr_d;
      wgt_rd_en_q <= (state_d == LOAD);
      if (state_d == LOAD) wgt_addr_q <= wgt_full[ADDR_W-1:0];
      act_rd_en_q <= beat;
      if (beat) begin
        act_addr_q <= act_full[ADDR_W-1:0];
        tm_q <= m_q; tn_q <= n_q; tk_q <= k_q;
      end
    end
  end

  // load_weight is wgt_rd_en delayed by the SRAM read latency; abort flushes it
  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) vld_pipe_q <= '0;
    else begin
      for (int i = RD_LAT; i > 1; i--) vld_pipe_q[i] <= vld_pipe_q[i-1];
      vld_pipe_q[1] <= wgt_rd_en_q;
    end
  end

  assign busy_o = busy_q;           assign done_o = done_q;           assign err_o = err_q;
  assign meta_req_o = meta_req_q;   assign meta_addr_o = meta_addr_q;
  assign wgt_rd_en_o = wgt_rd_en_q; assign wgt_addr_o = wgt_addr_q;
  assign act_rd_en_o = act_rd_en_q; assign act_addr_o = act_addr_q;
  assign pe_en_o = act_rd_en_q;     assign load_weight_o = vld_pipe_q[RD_LAT];
  assign tile_m_o = tm_q;           assign tile_n_o = tn_q;           assign tile_k_o = tk_q;
  assign blk_count_o = cnt_q;
endmodule

// File: tb/tb_bsr_tile_scheduler.sv
// Directed bench for bsr_tile_scheduler: sparse walk, empty row with slow
// metadata, dense fallback, backpressure, metadata errors, zero config, abort.
module tb_bsr_tile_scheduler;
  localparam int BS = 4, M_W = 10, N_W = 10, K_W = 12, ADDR_W = 32, META_AW = 16, RD_LAT = 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, cfg_dense = 1'b0;
  logic [M_W-1:0] cfg_mt = '0;
  logic [K_W-1:0] cfg_kt = '0;
  logic [N_W-1:0] cfg_nt = '0;
  logic [META_AW-1:0] cfg_rpb = '0, cfg_cib = '0;
  logic [ADDR_W-1:0] cfg_wb = '0, cfg_ab = '0;
  logic meta_rvalid = 1'b0, pe_ready = 1'b1;
  logic [31:0] meta_rdata = '0;
  logic busy, done, err, meta_req, wgt_rd_en, act_rd_en, load_weight, pe_en;
  logic [META_AW-1:0] meta_addr;
  logic [ADDR_W-1:0] wgt_addr, act_addr;
  logic [M_W-1:0] tile_m;
  logic [N_W-1:0] tile_n;
  logic [K_W-1:0] tile_k;
  logic [31:0] blk_count;

  always #5 clk = ~clk;

  bsr_tile_scheduler #(.BLOCK_SIZE(BS), .M_W(M_W), .N_W(N_W), .K_W(K_W),
                       .ADDR_W(ADDR_W), .META_AW(META_AW), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done), .err_o(err),
    .cfg_mt_i(cfg_mt), .cfg_kt_i(cfg_kt), .cfg_nt_i(cfg_nt), .cfg_dense_i(cfg_dense),
    .cfg_row_ptr_base_i(cfg_rpb), .cfg_col_idx_base_i(cfg_cib),
    .cfg_wgt_base_i(cfg_wb), .cfg_act_base_i(cfg_ab),
    .meta_req_o(meta_req), .meta_addr_o(meta_addr),
    .meta_rvalid_i(meta_rvalid), .meta_rdata_i(meta_rdata),
    .wgt_rd_en_o(wgt_rd_en), .wgt_addr_o(wgt_addr),
    .act_rd_en_o(act_rd_en), .act_addr_o(act_addr),
    .load_weight_o(load_weight), .pe_en_o(pe_en), .pe_ready_i(pe_ready),
    .tile_m_o(tile_m), .tile_n_o(tile_n), .tile_k_o(tile_k), .blk_count_o(blk_count));

  int total = 0, bad = 0;
  logic [31:0] mem [0:63];
  int lat = 0;
  int done_cnt = 0, meta_cyc = 0, lw_viol = 0, bp_viol = 0, pa_viol = 0, addr_glitch = 0;
  logic [31:0] wq[$];
  logic [63:0] bq[$];
  logic h1 = 1'b0, h2 = 1'b0, prdy = 1'b0;

  function automatic logic [63:0] pk(input int m, input int n, input int k, input int a);
    return {10'(m), 10'(n), 12'(k), 32'(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wq.delete(); bq.delete(); meta_cyc = 0; bp_viol = 0; addr_glitch = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Pulse start, wait (bounded) for done, then let the pipeline drain a little.
  task automatic go(input string tag);
    int n0, cyc;
    n0 = done_cnt; cyc = 0;
    start = 1'b1; step(); start = 1'b0;
    while (done_cnt == n0 && cyc < 3000) begin step(); cyc++; end
    chk({tag, " done"}, 64'(done_cnt - n0), 64'd1);
    repeat (4) step();
    chk({tag, " single done"}, 64'(done_cnt - n0), 64'd1);
  endtask

  // Per-cycle observation: reads, beats, handshake and latency invariants
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (meta_req) meta_cyc++;
    if (wgt_rd_en) wq.push_back(wgt_addr);
    if (pe_en) bq.push_back({tile_m, tile_n, tile_k, act_addr});
    if (pe_en !== act_rd_en) pa_viol++;
    if (pe_en && !prdy) bp_viol++;
    if (load_weight !== h2) lw_viol++;
    h2 = h1; h1 = wgt_rd_en; prdy = pe_ready;
  end

  // Metadata responder with programmable wait states
  initial begin : resp
    logic [META_AW-1:0] ha;
    int w;
    w = 0; ha = '0;
    forever begin
      @(posedge clk); #1;
      if (meta_req) begin
        if (w > 0 && meta_addr !== ha) addr_glitch++;
        ha = meta_addr;
        if (w >= lat) begin meta_rvalid = 1'b1; meta_rdata = mem[meta_addr[5:0]]; w = 0; end
        else begin meta_rvalid = 1'b0; w++; end
      end else begin
        meta_rvalid = 1'b0; w = 0;
      end
    end
  end

  initial begin
    logic [63:0] eb [0:8];
    int cyc, d0;
    logic [0:4] pat;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) step();
    chk("reset strobes", 64'({busy, done, err, meta_req, wgt_rd_en, act_rd_en, load_weight, pe_en}), 64'd0);
    chk("reset addrs", {meta_addr, wgt_addr[15:0], act_addr}, 64'd0);
    chk("reset count", 64'(blk_count), 64'd0);
    rst = 1'b0; step();

    // Sparse walk: 3 blocks over 2 K tiles
    mem[0] = 0; mem[1] = 2; mem[2] = 3; mem[16] = 1; mem[17] = 3; mem[18] = 0;
    cfg_rpb = 0; cfg_cib = 16; cfg_wb = 0; cfg_ab = 0;
    cfg_kt = 2; cfg_mt = 3; cfg_nt = 4; cfg_dense = 0; lat = 0;
    clr(); go("sparse");
    chk("sparse wgt n", 64'(wq.size()), 64'd12);
    for (int i = 0; i < 12; i++) chk("sparse wgt addr", (i < wq.size()) ? 64'(wq[i]) : 'x, 64'(i));
    eb[0] = pk(0,1,0,0); eb[1] = pk(1,1,0,2); eb[2] = pk(2,1,0,4);
    eb[3] = pk(0,3,0,0); eb[4] = pk(1,3,0,2); eb[5] = pk(2,3,0,4);
    eb[6] = pk(0,0,1,1); eb[7] = pk(1,0,1,3); eb[8] = pk(2,0,1,5);
    chk("sparse beat n", 64'(bq.size()), 64'd9);
    for (int i = 0; i < 9; i++) chk("sparse beat", (i < bq.size()) ? bq[i] : 'x, eb[i]);
    chk("sparse blk_count", 64'(blk_count), 64'd3);
    chk("sparse err", 64'(err), 64'd0);
    chk("sparse meta cycles", 64'(meta_cyc), 64'd7);

    // Empty row for k=0 with 5-cycle metadata latency
    mem[0] = 0; mem[1] = 0; mem[2] = 1; mem[16] = 2;
    cfg_kt = 2; cfg_mt = 1; cfg_nt = 4; lat = 5;
    clr(); go("empty");
    chk("empty wgt n", 64'(wq.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("empty wgt addr", (i < wq.size()) ? 64'(wq[i]) : 'x, 64'(i));
    chk("empty beat n", 64'(bq.size()), 64'd1);
    chk("empty beat", (bq.size() > 0) ? bq[0] : 'x, pk(0,2,1,1));
    chk("empty blk_count", 64'(blk_count), 64'd1);
    chk("empty meta stable", 64'(addr_glitch), 64'd0);
    chk("empty meta cycles", 64'(meta_cyc), 64'd30);
    lat = 0;

    // Dense fallback
    cfg_dense = 1; cfg_kt = 2; cfg_nt = 2; cfg_mt = 1; cfg_wb = 32'h100;
    clr(); go("dense");
    chk("dense wgt n", 64'(wq.size()), 64'd16);
    for (int i = 0; i < 16; i++) chk("dense wgt addr", (i < wq.size()) ? 64'(wq[i]) : 'x, 64'(32'h100 + i));
    eb[0] = pk(0,0,0,0); eb[1] = pk(0,1,0,0); eb[2] = pk(0,0,1,1); eb[3] = pk(0,1,1,1);
    chk("dense beat n", 64'(bq.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("dense beat", (i < bq.size()) ? bq[i] : 'x, eb[i]);
    chk("dense no meta", 64'(meta_cyc), 64'd0);
    chk("dense blk_count", 64'(blk_count), 64'd4);

    // Backpressure during STREAM: pe_ready 1,0,0,1,1
    cfg_dense = 1; cfg_kt = 1; cfg_nt = 1; cfg_mt = 3; cfg_wb = 32'h200; cfg_ab = 32'h40;
    clr(); pe_ready = 1'b0; d0 = done_cnt; cyc = 0; pat = 5'b10011;
    start = 1'b1; step(); start = 1'b0;
    while (!wgt_rd_en && cyc < 100) begin step(); cyc++; end
    while (wgt_rd_en && cyc < 100) begin step(); cyc++; end
    chk("bp reach stream", 64'(cyc < 100), 64'd1);
    for (int i = 0; i < 5; i++) begin pe_ready = pat[i]; step(); end
    pe_ready = 1'b1;
    while (done_cnt == d0 && cyc < 200) begin step(); cyc++; end
    repeat (3) step();
    chk("bp done", 64'(done_cnt - d0), 64'd1);
    chk("bp beat n", 64'(bq.size()), 64'd3);
    for (int i = 0; i < 3; i++) chk("bp beat", (i < bq.size()) ? bq[i] : 'x, pk(i, 0, 0, 32'h40 + i));
    chk("bp no stalled beat", 64'(bp_viol), 64'd0);
    chk("bp wgt first", (wq.size() > 0) ? 64'(wq[0]) : 'x, 64'h200);

    // Column index out of range
    cfg_dense = 0; cfg_wb = 0; cfg_ab = 0;
    mem[0] = 0; mem[1] = 1; mem[16] = 4; cfg_kt = 1; cfg_nt = 4; cfg_mt = 1;
    clr(); go("colerr");
    chk("colerr err", 64'(err), 64'd1);
    chk("colerr no load", 64'(wq.size()), 64'd0);

    // Zero config: done two cycles after start, no reads, err cleared by start
    cfg_mt = 0; cfg_kt = 1; cfg_nt = 1;
    clr(); d0 = done_cnt;
    start = 1'b1; step(); start = 1'b0;
    chk("zero t+1 busy/done", 64'({busy, done}), 64'b10);
    step();
    chk("zero t+2 busy/done", 64'({busy, done}), 64'b01);
    repeat (3) step();
    chk("zero err cleared", 64'(err), 64'd0);
    chk("zero no reads", 64'(wq.size() + meta_cyc), 64'd0);
    chk("zero done n", 64'(done_cnt - d0), 64'd1);

    // Decreasing row pointers
    mem[0] = 3; mem[1] = 1; cfg_mt = 1; cfg_kt = 1; cfg_nt = 4;
    clr(); go("ptrerr");
    chk("ptrerr err", 64'(err), 64'd1);
    chk("ptrerr no load", 64'(wq.size()), 64'd0);

    // Abort in the second block's stream, then a clean rerun
    mem[0] = 0; mem[1] = 2; mem[2] = 3; mem[16] = 1; mem[17] = 3; mem[18] = 0;
    cfg_kt = 2; cfg_mt = 3; cfg_nt = 4;
    clr(); d0 = done_cnt; cyc = 0;
    start = 1'b1; step(); start = 1'b0;
    while (!(blk_count == 1 && pe_en) && cyc < 500) begin step(); cyc++; end
    chk("abort reach stream", 64'(cyc < 500), 64'd1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort strobes", 64'({busy, done, meta_req, wgt_rd_en, act_rd_en, pe_en, load_weight}), 64'd0);
    repeat (10) step();
    chk("abort no done", 64'(done_cnt - d0), 64'd0);
    clr(); go("rerun");
    chk("rerun blk_count", 64'(blk_count), 64'd3);
    chk("rerun beats", 64'(bq.size()), 64'd9);
    chk("rerun wgt n", 64'(wq.size()), 64'd12);

    chk("load_weight lag", 64'(lw_viol), 64'd0);
    chk("pe_en==act_rd_en", 64'(pa_viol), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
